// File: rtl/ascii_uart_tx.sv
// Serialises 7-bit ASCII characters: start, D0..D6 LSB first, optional even parity, stop.
// Latency: a character accepted onto an idle, empty block drives its start bit from the next edge.
// Backpressure: char_rdy drops while the character FIFO is full; offers made then are dropped and set sticky ovf.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] char,
    input  logic       char_vld,
    output logic       char_rdy,
    output logic       txd,
    output logic       busy,
    output logic       ovf
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Character FIFO storage and bookkeeping
    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [6:0]    head;

    // Serializer state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_d;
    logic          last;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    // Reset gates readiness so a push coincident with the reset edge is never taken.
    assign char_rdy = !full && rst_n;
    assign push     = char_vld && char_rdy;
    assign head     = mem[rd_ptr];
    assign last     = (cnt_q == CNT_LAST);
    assign busy     = (state_q != IDLE) || !empty;

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= char;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same edge leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: an offer refused while out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (char_vld && !char_rdy) begin
            ovf <= 1'b1;
        end
    end

    // Serializer registers; txd is registered from the next-state value so it has no path from char
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd     <= txd_d;
        end
    end

    // Next-state, counters, FIFO pop and the line value for the coming cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        txd_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = ^head;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd6) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        par_d   = ^head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
module tb_ascii_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] char_in = '0;
    logic       char_vld = 1'b0;
    logic       char_rdy, txd, busy, ovf;

    logic [6:0] np_char = '0;
    logic       np_vld = 1'b0;
    logic       np_rdy, np_txd, np_busy, np_ovf;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    // Reference model: each accepted character has an accept edge k and a start edge s.
    int         m_k[$];
    int         m_s[$];
    logic [6:0] m_c[$];
    logic       m_ovf = 1'b0;

    logic obs_rdy, obs_txd, obs_busy, obs_ovf;
    logic exp_rdy, exp_txd, exp_busy, exp_ovf;
    logic acc_dut;

    always #5 clk = ~clk;

    ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .char(char_in), .char_vld(char_vld),
        .char_rdy(char_rdy), .txd(txd), .busy(busy), .ovf(ovf)
    );

    ascii_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .PARITY_EN(0)) u_dut_np (
        .clk(clk), .rst_n(rst_n), .char(np_char), .char_vld(np_vld),
        .char_rdy(np_rdy), .txd(np_txd), .busy(np_busy), .ovf(np_ovf)
    );

    // Characters sitting in the FIFO just before edge t: accepted earlier, not yet started.
    function automatic int occ(input int t);
        int n = 0;
        foreach (m_k[i]) if (m_k[i] < t && t <= m_s[i]) n++;
        return n;
    endfunction

    function automatic logic frame_bit(input logic [6:0] c, input int b, input int par);
        if (b == 0) return 1'b0;
        if (b <= 7) return c[b-1];
        if (par != 0 && b == 8) return ^c;
        return 1'b1;
    endfunction

    function automatic logic model_txd(input int t);
        foreach (m_s[i]) if (m_s[i] <= t && t < m_s[i] + FL) return frame_bit(m_c[i], (t - m_s[i]) / CPB, 1);
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int t);
        foreach (m_s[i]) if (m_k[i] <= t && t < m_s[i] + FL) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, sample readiness, advance the model at the edge, sample outputs at negedge.
    task automatic cycle(input logic v, input logic [6:0] c, input logic r);
        int s;
        char_vld = v;
        char_in  = c;
        rst_n    = r;
        #1;
        obs_rdy = char_rdy;
        exp_rdy = r && (occ(ecount) < DEPTH);
        @(posedge clk);
        if (!r) begin
            m_k.delete(); m_s.delete(); m_c.delete();
            m_ovf = 1'b0;
        end else if (v && exp_rdy) begin
            s = ecount + 1;
            if (m_s.size() > 0 && m_s[$] + FL > s) s = m_s[$] + FL;
            m_k.push_back(ecount); m_s.push_back(s); m_c.push_back(c);
        end else if (v) begin
            m_ovf = 1'b1;
        end
        acc_dut = v && obs_rdy;
        @(negedge clk);
        obs_txd  = txd;
        obs_busy = busy;
        obs_ovf  = ovf;
        exp_txd  = model_txd(ecount);
        exp_busy = model_busy(ecount);
        exp_ovf  = m_ovf;
        ecount++;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 7'h41, 1'b0);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== 4'b0100) begin
                errors++;
                $display("FAIL reset_hold rdy/txd/busy/ovf got %b want 0100", {obs_rdy, obs_txd, obs_busy, obs_ovf});
            end
        end
        cycle(1'b0, 7'h00, 1'b1);
        checks++;
        if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release rdy/txd/busy/ovf got %b want 1100", {obs_rdy, obs_txd, obs_busy, obs_ovf});
        end
    endtask

    task automatic test_single;
        logic [9:0] tpat = 10'b1110101000;   // 'T' frame bits, index 0 = start bit
        for (int i = 0; i < 46; i++) begin
            cycle(i == 0, 7'h54, 1'b1);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL single t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
            if (i >= 1 && i <= 40) begin
                checks++;
                if (obs_txd !== tpat[(i-1)/4]) begin
                    errors++;
                    $display("FAIL single_pattern t=%0d txd got %b want %b", i, obs_txd, tpat[(i-1)/4]);
                end
            end
            if (i == 41) begin
                checks++;
                if (obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_fall busy got %b want 0", obs_busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] chars [3] = '{7'h54, 7'h61, 7'h6C};
        logic [2:0] pbits = 3'b011;          // bit j = parity of frame j
        for (int i = 0; i < 126; i++) begin
            cycle(i < 3, (i < 3) ? chars[i] : 7'h00, 1'b1);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL b2b t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
            if (i >= 1 && i <= 120 && obs_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy t=%0d busy got %b want 1", i, obs_busy);
            end
            for (int j = 0; j < 3; j++) begin
                if (i == 1 + 40*j + 33) begin
                    checks++;
                    if (obs_txd !== pbits[j]) begin
                        errors++;
                        $display("FAIL b2b_parity frame=%0d got %b want %b", j, obs_txd, pbits[j]);
                    end
                end
                if (i == 1 + 40*j) begin
                    checks++;
                    if (obs_txd !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_start frame=%0d got %b want 0", j, obs_txd);
                    end
                end
            end
        end
    endtask

    task automatic test_push_pop;
        logic [6:0] chars [5] = '{7'h41, 7'h20, 7'h62, 7'h63, 7'h64};
        for (int i = 0; i < 212; i++) begin
            cycle(i < 6, (i < 5) ? chars[i] : 7'h65, 1'b1);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL pushpop t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
            // Push/pop at edge 1 keeps count at 1, so three more fit and only the sixth offer is refused.
            if (i >= 1 && i <= 4) begin
                checks++;
                if (obs_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL pushpop_rdy t=%0d rdy got %b want 1", i, obs_rdy);
                end
            end
            if (i == 5) begin
                checks++;
                if (obs_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL pushpop_full rdy got %b want 0", obs_rdy);
                end
            end
            if (i == 74) begin
                checks++;
                if (obs_txd !== 1'b1) begin
                    errors++;
                    $display("FAIL pushpop_space_parity got %b want 1", obs_txd);
                end
            end
        end
        // Clear the sticky overflow from the refused sixth offer.
        cycle(1'b0, 7'h00, 1'b0);
    endtask

    task automatic test_overflow;
        string name = "Talal Jawaid ";
        byte   b;
        int    accepted = 0;
        for (int i = 0; i < 216; i++) begin
            b = (i < 13) ? name[i] : 8'h00;
            cycle(i < 13, b[6:0], 1'b1);
            if (acc_dut) accepted++;
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL overflow t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
        end
        checks++;
        if (accepted != 5) begin
            errors++;
            $display("FAIL overflow_count accepted %0d want 5", accepted);
        end
        checks++;
        if (obs_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky ovf got %b want 1", obs_ovf);
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] chars [4] = '{7'h4A, 7'h61, 7'h77, 7'h69};
        for (int i = 0; i < 80; i++) begin
            cycle(i < 4, (i < 4) ? chars[i] : 7'h00, i != 18);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL reset_mid t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
            if (i == 18) begin
                checks++;
                if ({obs_txd, obs_busy, obs_ovf} !== 3'b100) begin
                    errors++;
                    $display("FAIL reset_mid_after txd/busy/ovf got %b want 100", {obs_txd, obs_busy, obs_ovf});
                end
            end
            if (i == 19) begin
                checks++;
                if (obs_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_mid_rdy rdy got %b want 1", obs_rdy);
                end
            end
            if (i > 18 && obs_txd !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_quiet t=%0d txd got %b want 1", i, obs_txd);
            end
        end
    endtask

    task automatic test_no_parity;
        logic [10:0] wseq = 11'b11111101110;   // index 0 = first cycle after accept+1
        for (int i = 0; i < 12; i++) begin
            np_vld  = (i == 0);
            np_char = 7'h77;
            cycle(1'b0, 7'h00, 1'b1);
            if (i >= 1) begin
                checks++;
                if (np_txd !== wseq[i-1]) begin
                    errors++;
                    $display("FAIL noparity_txd t=%0d got %b want %b", i, np_txd, wseq[i-1]);
                end
            end
            if (i == 10) begin
                checks++;
                if ({np_busy, np_ovf} !== 2'b00) begin
                    errors++;
                    $display("FAIL noparity_idle busy/ovf got %b want 00", {np_busy, np_ovf});
                end
            end
        end
        np_vld = 1'b0;
    endtask

    task automatic test_random;
        logic v;
        for (int i = 0; i < 860; i++) begin
            if (i >= 600)              v = 1'b0;
            else if ((i % 200) < 20)   v = ($urandom_range(0, 1) == 1);
            else                       v = ($urandom_range(0, 39) == 0);
            cycle(v, 7'($urandom_range(0, 127)), ($urandom_range(0, 499) != 0) || i >= 600);
            checks++;
            if ({obs_rdy, obs_txd, obs_busy, obs_ovf} !== {exp_rdy, exp_txd, exp_busy, exp_ovf}) begin
                errors++;
                $display("FAIL random t=%0d rdy/txd/busy/ovf got %b want %b", i, {obs_rdy, obs_txd, obs_busy, obs_ovf}, {exp_rdy, exp_txd, exp_busy, exp_ovf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_push_pop();
        test_overflow();
        test_reset_mid();
        test_no_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_uart_tx.md
# ascii_uart_tx

Serial output stage for the name-pattern generator: it takes the 7-bit ASCII characters produced by the character coder and transmits them on a single line. Characters pass through a small FIFO into a UART-style serializer. Each frame is a start bit, 7 data bits LSB first, an optional even-parity bit, and a stop bit. The block sits directly downstream of the coder. A strobe (CHAR_VLD) marks each new character.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range ≥ 1.
- FIFO_DEPTH, default 4: character FIFO entries; power of 2, ≥ 2.
- PARITY_EN, default 1: 1 inserts an even-parity bit after D6; 0 omits it.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- CHAR  input  7  ASCII character from the coder, bit 0 = LSB.
- CHAR_VLD  input  1  character offered this cycle.
- CHAR_RDY  output  1  block can accept a character this cycle.
- TXD  output  1  serial line; idles at 1.
- BUSY  output  1  a frame is in flight or the FIFO is non-empty.
- OVF  output  1  sticky flag: a character was offered while CHAR_RDY was 0.

## Operation
- Reset (RST_N sampled low at a rising edge) clears everything:
  - TXD=1, BUSY=0, OVF=0.
  - FIFO empty; FSM goes to IDLE; all counters are 0.
  - CHAR_RDY is forced to 0 while RST_N is low, and is 1 after reset.
- Push: CHAR is written to the FIFO when CHAR_VLD & CHAR_RDY at the edge.
  - CHAR_RDY = !full & RST_N.
- Push and pop in the same cycle are legal whenever the FIFO is not full. Count is unchanged.
- A push offered while full is rejected even if a pop happens in the same cycle.
- OVF is set at any edge where CHAR_VLD=1 and CHAR_RDY=0 (RST_N high). It is cleared only by reset.
- FSM states and TXD value in each:
  - IDLE: TXD=1.
  - START: TXD=0.
  - DATA: TXD=shift[0]; 7 bits, LSB first.
  - PARITY: TXD = XOR of the 7 data bits.
  - STOP: TXD=1.
- FSM transitions:
  - IDLE → START when the FIFO is non-empty. This pops the head into a 7-bit shift register and latches parity.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after 7 bit periods, or DATA → STOP if PARITY_EN=0.
  - PARITY → STOP after one bit period.
  - STOP, last cycle → START if the FIFO is non-empty (pop; back-to-back, no idle gap), else → IDLE.
- Counters:
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The data-bit counter counts 0..6.
  - The shift register shifts right once per bit period in DATA.
- BUSY = (state != IDLE) | !empty.

## Timing
- TXD is a register output; it never has a combinational path from CHAR.
- Latency: a character accepted at edge E onto an idle, empty block drives TXD=0 from edge E+1.
- Frame length:
  - PARITY_EN=1: 10 × CLKS_PER_BIT cycles.
  - PARITY_EN=0: 9 × CLKS_PER_BIT cycles.
- Every bit is held for exactly CLKS_PER_BIT cycles, including with CLKS_PER_BIT=1.
- Consecutive frames are contiguous: the cycle after the last stop-bit cycle is the next start bit.
- Buffering capacity is FIFO_DEPTH characters plus one in the shift register. When empty, the first accepted character leaves the FIFO one edge after its push.
- Reset mid-frame aborts the frame:
  - TXD=1 from the reset edge onward.
  - Queued characters are discarded and no partial frame resumes.
  - A push coincident with the reset edge is dropped.
- CHAR is sampled only on the accepting edge; later changes on CHAR do not affect a queued character.

## Test plan
- Single character, CLKS_PER_BIT=4, PARITY_EN=1: push 'T' (0x54) once when idle.
  - TXD bit sequence: 0 | 0,0,1,0,1,0,1 | 1 | 1, each bit held 4 cycles.
  - Start bit begins one edge after the accept; 40 cycles total.
  - BUSY falls after the stop bit.
- Back-to-back: push 'T','a','l' (0x54, 0x61, 0x6C) on 3 consecutive cycles.
  - Three contiguous frames over 120 cycles, with parity bits 1, 1, 0.
  - BUSY is high throughout and TXD shows no idle 1 between a stop bit and the next start bit.
- Fill and overflow, FIFO_DEPTH=4: hold CHAR_VLD=1 with "Talal Jawaid " presented one character per cycle.
  - Exactly 5 characters ('T','a','l','a','l') are accepted.
  - CHAR_RDY=0 after the 5th accept edge; OVF=1 on the following edge and stays 1.
  - Output is those 5 frames in order.
- Reset mid-operation: RST_N low for one edge during data bit D3 of the first frame, with 3 characters queued.
  - After the edge: TXD=1, BUSY=0, OVF=0, CHAR_RDY=1.
  - No further frames are sent until a new push.
- No parity, CLKS_PER_BIT=1, PARITY_EN=0: push 'w' (0x77).
  - TXD over 9 consecutive cycles: 0,1,1,1,0,1,1,1,1, then idle 1.
- Simultaneous push and pop: with the FIFO at count 1 and a pop coinciding with a push of ' ' (0x20).
  - Count stays 1 and CHAR_RDY stays 1.
  - ' ' later transmits with parity bit 1.
